mem_dump: RTL and testbench

Post-halt memory dump engine for the VeriRISC core. Once the processor halts, it reads every word of the shared program/data memory in ascending address order. Each word is presented with its address on a valid/ready output stream for a testbench monitor or debug port. It is the read-side counterpart of the processor's store path: the core writes memory, and this block reads it back out.

---
 rtl/mem_dump_pkg.sv | 17 +
 rtl/mem_dump.sv | 149 ++++++++++++++
 tb/tb_mem_dump.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types and default geometry for the VeriRISC post-halt memory dump engine.
package mem_dump_pkg;

    localparam int unsigned MEM_AWIDTH = 5;
    localparam int unsigned MEM_DWIDTH = 8;

    // ST_CKSUM is always encoded so the state map is identical across builds.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_CKSUM = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/mem_dump.sv
// Post-halt memory dump: streams every memory word with its address on a valid/ready port.
// Optional trailing checksum word enabled by defining MEM_DUMP_CHECKSUM_EN.
module mem_dump
    import mem_dump_pkg::*;
#(
    parameter int unsigned AWIDTH = MEM_AWIDTH,
    parameter int unsigned DWIDTH = MEM_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [AWIDTH-1:0] out_addr,
    output logic              out_last
);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] ptr_q, ptr_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic [AWIDTH-1:0] out_addr_q, out_addr_d;
    logic              out_last_q, out_last_d;
    logic              ptr_is_last;

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DWIDTH-1:0] csum_q, csum_d;
`endif

    assign ptr_is_last = (ptr_q == '1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        mem_addr_d = mem_addr_q;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
        out_last_d = out_last_q;
`ifdef MEM_DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_READ;
                    ptr_d      = '0;
                    mem_addr_d = '0;
`ifdef MEM_DUMP_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                out_data_d = mem_data;
                out_addr_d = ptr_q;
`ifdef MEM_DUMP_CHECKSUM_EN
                out_last_d = 1'b0;
                csum_d     = csum_q + mem_data;
`else
                out_last_d = ptr_is_last;
`endif
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (ptr_is_last) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                        // csum_q already includes the final word captured in WAIT
                        state_d    = ST_CKSUM;
                        out_data_d = csum_q;
                        out_addr_d = '0;
                        out_last_d = 1'b1;
`else
                        state_d    = ST_DONE;
`endif
                    end else begin
                        state_d    = ST_READ;
                        ptr_d      = ptr_q + AWIDTH'(1);
                        mem_addr_d = ptr_q + AWIDTH'(1);
                    end
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            ST_CKSUM: begin
                if (out_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            mem_addr_q <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            mem_addr_q <= mem_addr_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
            out_last_q <= out_last_d;
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign mem_rd    = (state_q == ST_READ);
    assign mem_addr  = mem_addr_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    assign out_valid = (state_q == ST_SEND) || (state_q == ST_CKSUM);
`else
    assign out_valid = (state_q == ST_SEND);
`endif
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mem_dump.sv
// Directed scoreboard bench for mem_dump; honours MEM_DUMP_CHECKSUM_EN like the RTL.
module tb_mem_dump;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int DEPTH = 32;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int NWORDS   = DEPTH + 1;
    localparam int DONE_LAT = 3 * DEPTH + 2;
`else
    localparam int NWORDS   = DEPTH;
    localparam int DONE_LAT = 3 * DEPTH + 1;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;

    logic [DW-1:0] mem [DEPTH];
    word_t         exp_q[$];
    int            tests = 0;
    int            fails = 0;

    mem_dump #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Synchronous memory, one-cycle read latency; junk data when not read.
    always @(posedge clk) begin
        mem_data <= mem_rd ? mem[mem_addr] : 8'hEE;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs_vec();
        return {11'd0, busy, done, mem_rd, mem_addr, out_valid, out_data, out_addr, out_last};
    endfunction

    task automatic push_expected();
        logic [DW-1:0] sum;
        word_t w;
        sum = '0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            w.a = AW'(i);
            w.d = mem[i];
`ifdef MEM_DUMP_CHECKSUM_EN
            w.l = 1'b0;
`else
            w.l = (i == DEPTH - 1);
`endif
            sum = sum + mem[i];
            exp_q.push_back(w);
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        w.a = '0;
        w.d = sum;
        w.l = 1'b1;
        exp_q.push_back(w);
`endif
    endtask

    // Runs one dump from the current (posedge+1) point. rand_rdy selects random backpressure,
    // dup_at re-pulses start at that cycle, rst_at asserts reset when word at that address is offered.
    task automatic run_dump(input bit rand_rdy, input int dup_at, input int rst_at,
                            output int words, output int done_cyc, output int done_cnt);
        int            cyc;
        bit            stall;
        bit            after_done_checked;
        logic [DW-1:0] hd;
        logic [AW-1:0] ha;
        logic          hl;
        word_t         w;
        words = 0; done_cyc = 0; done_cnt = 0; cyc = 0; stall = 0; after_done_checked = 0;
        hd = '0; ha = '0; hl = 1'b0;
        start = 1'b1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        while (cyc < 1000) begin
            step();
            cyc++;
            start = (cyc == dup_at);
            if (rst_at >= 0 && out_valid === 1'b1 && out_addr == AW'(rst_at)) begin
                rst = 1'b0;
                #1;
                check("async_reset_outputs", outs_vec(), 32'd0);
                for (int k = 0; k < 3; k++) begin
                    step();
                    check("no_done_in_reset", {31'd0, done}, 32'd0);
                end
                rst = 1'b1;
                start = 1'b0;
                return;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    check("busy_during_done", {31'd0, busy}, 32'd1);
                end
            end
            if (done_cnt > 0 && cyc == done_cyc + 1 && !after_done_checked) begin
                after_done_checked = 1;
                check("busy_after_done", {31'd0, busy}, 32'd0);
            end
            if (stall) begin
                check("valid_held", {31'd0, out_valid}, 32'd1);
                check("payload_held", {19'd0, out_addr, out_data, out_last}, {19'd0, ha, hd, hl});
            end
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid === 1'b1 && out_ready) begin
                words++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {27'd0, out_addr}, 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    check("word_addr", {27'd0, out_addr}, {27'd0, w.a});
                    check("word_data", {24'd0, out_data}, {24'd0, w.d});
                    check("word_last", {31'd0, out_last}, {31'd0, w.l});
                end
            end
            stall = (out_valid === 1'b1) && !out_ready;
            hd = out_data; ha = out_addr; hl = out_last;
            if (done_cnt > 0 && cyc >= done_cyc + 6) break;
        end
        out_ready = 1'b0;
        if (rst_at < 0) begin
            check("done_within_budget", {31'd0, done_cnt > 0}, 32'd1);
        end
    endtask

    initial begin
        int words, dcyc, dcnt;
        rst = 1'b0; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i) ^ 8'hA5;

        // Reset then idle
        step();
        check("reset_outputs", outs_vec(), 32'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_outputs", outs_vec(), 32'd0);
        end

        // Full dump, no backpressure
        push_expected();
        run_dump(1'b0, -1, -1, words, dcyc, dcnt);
        check("full_words", words, NWORDS);
        check("full_done_latency", dcyc, DONE_LAT);
        check("full_done_count", dcnt, 1);
        check("full_queue_empty", exp_q.size(), 0);
        check("mem_addr_holds", {27'd0, mem_addr}, DEPTH - 1);

        // Random backpressure
        push_expected();
        run_dump(1'b1, -1, -1, words, dcyc, dcnt);
        check("bp_words", words, NWORDS);
        check("bp_done_count", dcnt, 1);
        check("bp_queue_empty", exp_q.size(), 0);

        // Uniform data: checksum 32*9 mod 256 = 8'h20 when enabled
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h09;
        push_expected();
`ifdef MEM_DUMP_CHECKSUM_EN
        check("cksum_model", {24'd0, exp_q[DEPTH].d}, 32'h20);
`endif
        run_dump(1'b0, -1, -1, words, dcyc, dcnt);
        check("nines_words", words, NWORDS);
        check("nines_queue_empty", exp_q.size(), 0);

        // start while busy
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 7 + 3);
        push_expected();
        run_dump(1'b0, 40, -1, words, dcyc, dcnt);
        check("dup_words", words, NWORDS);
        check("dup_done_count", dcnt, 1);
        check("dup_done_latency", dcyc, DONE_LAT);
        check("dup_queue_empty", exp_q.size(), 0);

        // Reset mid-dump at address 12, then restart from address 0
        push_expected();
        run_dump(1'b0, -1, 12, words, dcyc, dcnt);
        check("abort_words", words, 12);
        check("abort_done_count", dcnt, 0);
        step();
        check("post_reset_idle", outs_vec(), 32'd0);
        push_expected();
        run_dump(1'b0, -1, -1, words, dcyc, dcnt);
        check("restart_words", words, NWORDS);
        check("restart_done_latency", dcyc, DONE_LAT);
        check("restart_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
